coffee_controller: RTL and testbench
====================================

# coffee_controller

Control FSM of the coffee machine and the producer of the status lines consumed by the 7-segment display decoder. It takes drink-selection buttons, coin entries, a cancel request and three supply sensors. It runs selection, payment, sensor check, dispense and error-hold phases. At all times it drives exactly one of the nine one-hot message lines (S0..S3, SR, SP, SN, VL, M) that the display path turns into CE01/CL02/CC05/CP10, ERSR/ERSP/ERSN/ERDI or the standby pattern.

## Interface
- DISPENSE_CYCLES, 50_000_000: cycles the `dispense` output stays high per drink (≥1).
- HOLD_CYCLES, 100_000_000: cycles an error message is held (≥1).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- btn  in  4  drink buttons, levels: btn[0]=CE01 (price 1), btn[1]=CL02 (2), btn[2]=CC05 (5), btn[3]=CP10 (10).
- cancel  in  1  level; acted on at rising edge.
- coin_strobe  in  1  one-cycle pulse; coin_val valid with it.
- coin_val  in  4  coin value in credits; valid values 1, 2, 5, 10.
- sr_ok, sp_ok, sn_ok  in  1 each  supply sensors (water, powder, cup/nozzle); 1 = healthy.
- S0, S1, S2, S3  out  1 each  selected-drink message.
- SR, SP, SN  out  1 each  sensor-error message.
- VL  out  1  invalid-coin message.
- M  out  1  standby message.
- dispense  out  1  valve/brew enable.
- change_strobe  out  1  one-cycle pulse; change_val valid with it.
- change_val  out  5  credits to return.

## Operation
- States: IDLE, SELECTED, CHECK, DISPENSE, ERR_SENSOR, ERR_VAL.
- Message lines are Moore outputs decoded from registered state/selection. Exactly one is high in every cycle.
- IDLE drives M. SELECTED, CHECK and DISPENSE drive S[sel]. ERR_SENSOR drives the failing sensor's line. ERR_VAL drives VL.
- Buttons and cancel are edge-detected against a registered copy: rise = x & ~x_q.
- IDLE: a button rise latches sel and moves to SELECTED with credit=0. If several rise together, the lowest index wins. Coins in IDLE are ignored and not credited.
- SELECTED, coin strobe:
  - valid coin: credit += coin_val. If new credit ≥ price(sel), go to CHECK; else stay.
  - invalid coin: credit unchanged, go to ERR_VAL.
- Buttons are ignored in all states except IDLE.
- CHECK (one cycle), sensors evaluated in priority SR, SP, SN:
  - any sensor fails: go to ERR_SENSOR with the first failing sensor recorded; pulse change_strobe with change_val = credit (full refund).
  - all healthy: go to DISPENSE; pulse change_strobe with change_val = credit − price. The pulse fires even when change is 0.
- Credit is 5 bits, max 19 (9 + 10); no overflow possible.
- DISPENSE: dispense=1 for exactly DISPENSE_CYCLES cycles, then IDLE with credit cleared. Cancel is ignored.
- ERR_SENSOR: hold HOLD_CYCLES cycles, then IDLE.
- ERR_VAL: hold HOLD_CYCLES cycles, then SELECTED with credit preserved.
- Cancel rise in SELECTED or ERR_VAL: go to IDLE. Pulse change_strobe with change_val = credit only if credit > 0.
- Simultaneous cancel rise and coin strobe: cancel wins; the coin is not credited.

## Timing
- Reset values: M=1; all other message lines 0; dispense=0; change_strobe=0; change_val=0; credit=0; state IDLE.
- Button rise sampled at edge k: S[sel] is high from edge k on (1-cycle latency).
- Price-reaching coin at edge k: CHECK after k. At edge k+1, DISPENSE or ERR_SENSOR begins. change_strobe is high for the single cycle after edge k+1.
- `dispense` rises at the same edge that enters DISPENSE and falls after DISPENSE_CYCLES cycles. M rises at that same edge.
- Reset mid-operation (including mid-dispense): all outputs return to reset values at the next edge. No refund pulse; credit is lost.

## Structure
- Package coffee_pkg holds:
  - state enum;
  - price constants (1, 2, 5, 10);
  - valid-coin check function;
  - sensor-error index enum.
- Sub-module cycle_timer: loadable down-counter with a done flag. One instance is shared by the DISPENSE and error-hold phases, loaded with DISPENSE_CYCLES or HOLD_CYCLES on state entry.

## Test plan
- Normal purchase: DISPENSE_CYCLES=4, sensors ok. btn[1] rise, coins 1 then 2. Expect S1 asserted, then CHECK, change_strobe with change_val=1, dispense high exactly 4 cycles, then M.
- Sensor fail: sp_ok=0, btn[2], coin 5. Expect SP held HOLD_CYCLES, refund change_val=5, dispense never high, then M.
- Invalid coin: btn[0], coin_val=3. Expect VL held HOLD_CYCLES, return to S0 with credit 0. Then coin 1 → dispense.
- Cancel vs coin: btn[3], coin 5, then cancel rise and coin 10 in the same cycle. Expect IDLE, change_val=5, no dispense.
- Reset mid-dispense: assert RST during dispense. Expect dispense=0 and M=1 at the next edge, no change_strobe.
- Simultaneous buttons: btn=4'b1010 rising together. Expect S1 selected. Buttons pressed during DISPENSE are ignored. Check the one-hot invariant on message lines every cycle.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared types, price table and coin/button helpers for the coffee machine controller.
package coffee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_CHECK,
    ST_DISPENSE,
    ST_ERR_SENSOR,
    ST_ERR_VAL
  } state_t;

  // Order matches the evaluation priority in CHECK: water, powder, cup/nozzle.
  typedef enum logic [1:0] {
    SENS_SR,
    SENS_SP,
    SENS_SN
  } sensor_err_t;

  localparam int unsigned CREDIT_W = 5;

  localparam logic [CREDIT_W-1:0] PRICE_CE01 = 5'd1;
  localparam logic [CREDIT_W-1:0] PRICE_CL02 = 5'd2;
  localparam logic [CREDIT_W-1:0] PRICE_CC05 = 5'd5;
  localparam logic [CREDIT_W-1:0] PRICE_CP10 = 5'd10;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] sel);
    logic [CREDIT_W-1:0] p;
    case (sel)
      2'd0:    p = PRICE_CE01;
      2'd1:    p = PRICE_CL02;
      2'd2:    p = PRICE_CC05;
      default: p = PRICE_CP10;
    endcase
    return p;
  endfunction

  function automatic logic coin_is_valid(input logic [3:0] val);
    logic ok;
    case (val)
      4'd1, 4'd2, 4'd5, 4'd10: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lowest set index wins when several buttons rise in the same cycle.
  function automatic logic [1:0] first_set(input logic [3:0] rise);
    logic [1:0] idx;
    if (rise[0])      idx = 2'd0;
    else if (rise[1]) idx = 2'd1;
    else if (rise[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/coffee_if.sv
// Front-panel, sensor and display/valve signals of the coffee machine controller.
interface coffee_if;
  logic [3:0] btn;
  logic       cancel;
  logic       coin_strobe;
  logic [3:0] coin_val;
  logic       sr_ok;
  logic       sp_ok;
  logic       sn_ok;

  logic       S0, S1, S2, S3;
  logic       SR, SP, SN;
  logic       VL;
  logic       M;
  logic       dispense;
  logic       change_strobe;
  logic [4:0] change_val;

  // master drives the machine inputs; slave is the controller itself.
  modport master (
    output btn, cancel, coin_strobe, coin_val, sr_ok, sp_ok, sn_ok,
    input  S0, S1, S2, S3, SR, SP, SN, VL, M, dispense, change_strobe, change_val
  );

  modport slave (
    input  btn, cancel, coin_strobe, coin_val, sr_ok, sp_ok, sn_ok,
    output S0, S1, S2, S3, SR, SP, SN, VL, M, dispense, change_strobe, change_val
  );
endinterface

// File: rtl/coffee_cycle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module cycle_timer #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - WIDTH'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/coffee_controller.sv
// Coffee machine control FSM: selection, payment, sensor check, dispense and error hold.
module coffee_controller
  import coffee_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic     CLK,
  input  logic     RST,
  coffee_if.slave  bus
);

  localparam int unsigned MAX_CYC = (DISPENSE_CYCLES > HOLD_CYCLES) ? DISPENSE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Loading N-1 keeps the phase alive for exactly N cycles including the entry cycle.
  localparam logic [TW-1:0] DISP_LOAD = TW'(DISPENSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  sensor_err_t         err_q, err_d;
  logic [3:0]          btn_q;
  logic                cancel_q;
  logic                chg_strobe_q, chg_strobe_d;
  logic [CREDIT_W-1:0] chg_val_q, chg_val_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_done;

  logic [3:0]          btn_rise;
  logic                cancel_rise;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] price;

  assign btn_rise    = bus.btn & ~btn_q;
  assign cancel_rise = bus.cancel & ~cancel_q;
  assign credit_sum  = credit_q + CREDIT_W'(bus.coin_val);
  assign price       = price_of(sel_q);

  cycle_timer #(.WIDTH(TW)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      credit_q     <= '0;
      err_q        <= SENS_SR;
      btn_q        <= 4'd0;
      cancel_q     <= 1'b0;
      chg_strobe_q <= 1'b0;
      chg_val_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
      btn_q        <= bus.btn;
      cancel_q     <= bus.cancel;
      chg_strobe_q <= chg_strobe_d;
      chg_val_q    <= chg_val_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    credit_d     = credit_q;
    err_d        = err_q;
    chg_strobe_d = 1'b0;
    chg_val_d    = '0;
    tmr_load     = 1'b0;
    tmr_val      = HOLD_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (|btn_rise) begin
          sel_d    = first_set(btn_rise);
          credit_d = '0;
          state_d  = ST_SELECTED;
        end
      end

      ST_SELECTED: begin
        // Cancel outranks a coin arriving in the same cycle; that coin is dropped.
        if (cancel_rise) begin
          state_d      = ST_IDLE;
          credit_d     = '0;
          chg_strobe_d = (credit_q != '0);
          chg_val_d    = credit_q;
        end else if (bus.coin_strobe) begin
          if (coin_is_valid(bus.coin_val)) begin
            credit_d = credit_sum;
            if (credit_sum >= price) state_d = ST_CHECK;
          end else begin
            state_d  = ST_ERR_VAL;
            tmr_load = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        chg_strobe_d = 1'b1;
        if (!bus.sr_ok || !bus.sp_ok || !bus.sn_ok) begin
          state_d   = ST_ERR_SENSOR;
          chg_val_d = credit_q;
          tmr_load  = 1'b1;
          if (!bus.sr_ok)      err_d = SENS_SR;
          else if (!bus.sp_ok) err_d = SENS_SP;
          else                 err_d = SENS_SN;
        end else begin
          state_d   = ST_DISPENSE;
          chg_val_d = credit_q - price;
          tmr_load  = 1'b1;
          tmr_val   = DISP_LOAD;
        end
      end

      ST_DISPENSE, ST_ERR_SENSOR: begin
        if (tmr_done) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end

      ST_ERR_VAL: begin
        if (cancel_rise) begin
          state_d      = ST_IDLE;
          credit_d     = '0;
          chg_strobe_d = (credit_q != '0);
          chg_val_d    = credit_q;
        end else if (tmr_done) begin
          state_d = ST_SELECTED;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Message lines decode purely from registered state, so exactly one is ever high.
  always_comb begin
    bus.S0 = 1'b0;
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    bus.S3 = 1'b0;
    bus.SR = 1'b0;
    bus.SP = 1'b0;
    bus.SN = 1'b0;
    bus.VL = 1'b0;
    bus.M  = 1'b0;

    case (state_q)
      ST_SELECTED, ST_CHECK, ST_DISPENSE: begin
        case (sel_q)
          2'd0:    bus.S0 = 1'b1;
          2'd1:    bus.S1 = 1'b1;
          2'd2:    bus.S2 = 1'b1;
          default: bus.S3 = 1'b1;
        endcase
      end
      ST_ERR_SENSOR: begin
        case (err_q)
          SENS_SR: bus.SR = 1'b1;
          SENS_SP: bus.SP = 1'b1;
          default: bus.SN = 1'b1;
        endcase
      end
      ST_ERR_VAL: bus.VL = 1'b1;
      default:    bus.M  = 1'b1;
    endcase
  end

  assign bus.dispense      = (state_q == ST_DISPENSE);
  assign bus.change_strobe = chg_strobe_q;
  assign bus.change_val    = chg_val_q;

endmodule

// File: tb/tb_coffee_controller.sv
// Randomised scoreboard bench for coffee_controller with a transaction-level purchase model.
module tb_coffee_controller;

  localparam int D_CYC = 4;
  localparam int H_CYC = 6;

  typedef enum int {EV_CHG, EV_DISP, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       a;
    int       b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  int   price_tab[4] = '{1, 2, 5, 10};

  coffee_if ifc ();

  coffee_controller #(.DISPENSE_CYCLES(D_CYC), .HOLD_CYCLES(H_CYC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0..3 = S0..S3, 4 = SR, 5 = SP, 6 = SN, 7 = VL, 8 = M
  function automatic int line(input int i);
    case (i)
      0: return int'(ifc.S0);
      1: return int'(ifc.S1);
      2: return int'(ifc.S2);
      3: return int'(ifc.S3);
      4: return int'(ifc.SR);
      5: return int'(ifc.SP);
      6: return int'(ifc.SN);
      7: return int'(ifc.VL);
      8: return int'(ifc.M);
      default: return 0;
    endcase
  endfunction

  function automatic void expect_ev(input ev_kind_t k, input int a, input int b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endfunction

  function automatic bit is_valid_coin(input int v);
    return (v == 1) || (v == 2) || (v == 5) || (v == 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    ifc.coin_strobe = 1'b1;
    ifc.coin_val    = 4'(v);
    tick();
    ifc.coin_strobe = 1'b0;
    ifc.coin_val    = 4'd0;
  endtask

  task automatic wait_line(input string name, input int idx, input int budget);
    int n = 0;
    while (line(idx) != 1 && n < budget) begin
      tick();
      n++;
    end
    check(name, line(idx), 1);
  endtask

  task automatic press(input logic [3:0] pattern, input int sel);
    ifc.btn = pattern;
    tick();
    check("sel_line", line(sel), 1);
    check("sel_m_low", line(8), 0);
    ifc.btn = 4'd0;
  endtask

  // Purchase outcome from the machine rules: refund on any sensor fault, else change.
  task automatic expect_purchase(input int credit, input int sel);
    int fail_code;
    fail_code = !ifc.sr_ok ? 0 : !ifc.sp_ok ? 1 : !ifc.sn_ok ? 2 : -1;
    if (fail_code < 0) begin
      expect_ev(EV_CHG, credit - price_tab[sel], 0);
      expect_ev(EV_DISP, D_CYC, sel);
    end else begin
      expect_ev(EV_CHG, credit, 0);
      expect_ev(EV_ERR, fail_code, H_CYC);
    end
  endtask

  // ---------------- monitor ----------------
  int disp_len = 0;
  int disp_sel = -1;
  int err_code = -1;
  int err_len  = 0;

  task automatic observe(input ev_kind_t k, input int a, input int b);
    ev_t e;
    check("sb_event_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_kind", int'(k), int'(e.kind));
      check("sb_a", a, e.a);
      check("sb_b", b, e.b);
    end
  endtask

  function automatic int cur_s();
    for (int i = 0; i < 4; i++) if (line(i) == 1) return i;
    return -1;
  endfunction

  function automatic int cur_err();
    for (int i = 4; i < 8; i++) if (line(i) == 1) return i - 4;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      disp_len = 0;
      err_len  = 0;
      err_code = -1;
    end else begin
      int code;
      check("msg_onehot", $countones({ifc.S0, ifc.S1, ifc.S2, ifc.S3, ifc.SR, ifc.SP,
                                      ifc.SN, ifc.VL, ifc.M}), 1);
      if (ifc.change_strobe) observe(EV_CHG, int'(ifc.change_val), 0);

      if (ifc.dispense) begin
        if (disp_len == 0)            disp_sel = cur_s();
        else if (cur_s() != disp_sel) disp_sel = -2;
        disp_len++;
      end else if (disp_len > 0) begin
        observe(EV_DISP, disp_len, disp_sel);
        disp_len = 0;
      end

      code = cur_err();
      if (code != err_code && err_len > 0) begin
        observe(EV_ERR, err_code, err_len);
        err_len = 0;
      end
      if (code >= 0) err_len++;
      err_code = code;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ifc.btn         = 4'd0;
    ifc.cancel      = 1'b0;
    ifc.coin_strobe = 1'b0;
    ifc.coin_val    = 4'd0;
    ifc.sr_ok       = 1'b1;
    ifc.sp_ok       = 1'b1;
    ifc.sn_ok       = 1'b1;
    repeat (3) tick();

    check("rst_M", line(8), 1);
    check("rst_S0", line(0), 0);
    check("rst_VL", line(7), 0);
    check("rst_dispense", int'(ifc.dispense), 0);
    check("rst_change_strobe", int'(ifc.change_strobe), 0);
    check("rst_change_val", int'(ifc.change_val), 0);
    rst = 1'b0;
    tick();

    // Normal purchase: CL02, coins 1 + 2 -> change 1.
    press(4'b0010, 1);
    coin(1);
    expect_purchase(3, 1);
    coin(2);
    check("check_no_dispense", int'(ifc.dispense), 0);
    check("check_S1", line(1), 1);
    tick();
    check("disp_start", int'(ifc.dispense), 1);
    check("change_strobe_timing", int'(ifc.change_strobe), 1);
    check("change_val_normal", int'(ifc.change_val), 1);
    wait_line("normal_back_idle", 8, D_CYC + 5);
    check("normal_disp_off", int'(ifc.dispense), 0);

    // Powder fault: full refund, SP held.
    ifc.sp_ok = 1'b0;
    press(4'b0100, 2);
    expect_purchase(5, 2);
    coin(5);
    tick();
    check("sp_line", line(5), 1);
    check("sp_no_dispense", int'(ifc.dispense), 0);
    wait_line("sp_back_idle", 8, H_CYC + 5);
    ifc.sp_ok = 1'b1;

    // Invalid coin, then a valid one completes the purchase with zero change.
    press(4'b0001, 0);
    expect_ev(EV_ERR, 3, H_CYC);
    coin(3);
    check("vl_line", line(7), 1);
    wait_line("vl_back_sel", 0, H_CYC + 5);
    expect_purchase(1, 0);
    coin(1);
    wait_line("vl_purchase_idle", 8, D_CYC + 10);

    // Cancel and a coin in the same cycle: cancel wins, refund 5.
    press(4'b1000, 3);
    coin(5);
    expect_ev(EV_CHG, 5, 0);
    ifc.cancel      = 1'b1;
    ifc.coin_strobe = 1'b1;
    ifc.coin_val    = 4'd10;
    tick();
    ifc.coin_strobe = 1'b0;
    ifc.coin_val    = 4'd0;
    ifc.cancel      = 1'b0;
    check("cancel_idle", line(8), 1);
    tick();

    // Reset mid-dispense: no refund, everything back to reset values.
    press(4'b0001, 0);
    expect_ev(EV_CHG, 0, 0);
    coin(1);
    tick();
    check("rst_mid_disp_on", int'(ifc.dispense), 1);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_dispense", int'(ifc.dispense), 0);
    check("rst_mid_M", line(8), 1);
    check("rst_mid_strobe", int'(ifc.change_strobe), 0);
    check("rst_mid_val", int'(ifc.change_val), 0);
    rst = 1'b0;
    tick();

    // Simultaneous buttons pick the lowest index; buttons and cancel ignored while dispensing.
    press(4'b1010, 1);
    expect_purchase(2, 1);
    coin(2);
    tick();
    ifc.btn    = 4'b0001;
    ifc.cancel = 1'b1;
    tick();
    check("disp_ignores_btn", line(1), 1);
    check("disp_ignores_cancel", int'(ifc.dispense), 1);
    ifc.btn    = 4'd0;
    ifc.cancel = 1'b0;
    wait_line("simul_back_idle", 8, D_CYC + 5);

    // Randomised purchases.
    for (int n = 0; n < 40; n++) begin
      int pattern, sel, credit, r, v;
      bit done;
      ifc.sr_ok = ($urandom_range(0, 5) != 0);
      ifc.sp_ok = ($urandom_range(0, 5) != 0);
      ifc.sn_ok = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) begin
        coin(1 + $urandom_range(0, 9));
        tick();
      end
      pattern = $urandom_range(1, 15);
      sel = 0;
      while (!pattern[sel]) sel++;
      press(4'(pattern), sel);
      credit = 0;
      done   = 1'b0;
      for (int it = 0; !done; it++) begin
        repeat ($urandom_range(0, 2)) tick();
        r = (it >= 20) ? 9 : $urandom_range(0, 9);
        if (r == 0) begin
          if (credit > 0) expect_ev(EV_CHG, credit, 0);
          ifc.cancel = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            ifc.coin_strobe = 1'b1;
            ifc.coin_val    = 4'd10;
          end
          tick();
          ifc.cancel      = 1'b0;
          ifc.coin_strobe = 1'b0;
          ifc.coin_val    = 4'd0;
          check("rnd_cancel_idle", line(8), 1);
          tick();
          done = 1'b1;
        end else if (r == 1) begin
          do v = $urandom_range(0, 15); while (is_valid_coin(v));
          expect_ev(EV_ERR, 3, H_CYC);
          coin(v);
          check("rnd_vl", line(7), 1);
          wait_line("rnd_vl_back", sel, H_CYC + 5);
        end else begin
          v = (it >= 20) ? 10 : price_tab[$urandom_range(0, 3)];
          credit += v;
          if (credit >= price_tab[sel]) begin
            expect_purchase(credit, sel);
            coin(v);
            wait_line("rnd_back_idle", 8, D_CYC + H_CYC + 10);
            done = 1'b1;
          end else begin
            coin(v);
          end
        end
      end
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
